// File: rtl/lxr_ejtag_pkg.sv
// Shared definitions for the EJTAG four-phase handshake transmitter:
// FSM state encoding and default sizing constants.
package lxr_ejtag_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWaitHi = 2'd1,
    StWaitLo = 2'd2
  } hs_state_e;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefToCyc = 255;

endpackage

// File: rtl/ejtag_ack_sync.sv
// Two-flop synchronizer bringing the far-domain acknowledge into the local clock domain.
module ejtag_ack_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ack,
  output logic o_ack_s
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_ack;
      r_sync <= r_meta;
    end
  end

  assign o_ack_s = r_sync;

endmodule

// File: rtl/ejtag_hs_tx.sv
// Four-phase REQ/ACK transmitter handing one DATA_W word at a time to an asynchronous domain.
// Optional ACK timeout is compiled in with EJTAG_HS_TX_TIMEOUT_EN.
module ejtag_hs_tx
  import lxr_ejtag_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned TO_CYC = DefToCyc
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SEND_VALID,
  input  logic [DATA_W-1:0] SEND_DATA,
  output logic              SEND_READY,
  output logic              XFER_REQ,
  output logic [DATA_W-1:0] XFER_DATA,
  input  logic              XFER_ACK,
  output logic              DONE,
  output logic              ERR
);

  hs_state_e         r_state, w_state_d;
  logic [DATA_W-1:0] r_data, w_data_d;
  logic              r_req;
  logic              r_done, w_done_d;
  logic              w_ack_s;
  logic              w_ready;

  ejtag_ack_sync u_ack_sync (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_ack   (XFER_ACK),
    .o_ack_s (w_ack_s)
  );

  // A stale ACK from a previous (possibly reset-aborted) transfer blocks new accepts.
  assign w_ready = (r_state == StIdle) && !w_ack_s;

`ifdef EJTAG_HS_TX_TIMEOUT_EN
  localparam int unsigned CntW = (TO_CYC < 2) ? 1 : $clog2(TO_CYC + 1);

  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            r_to, w_to_d;
  logic            r_err, w_err_d;
`endif

  always_comb begin
    w_state_d = r_state;
    w_data_d  = r_data;
    w_done_d  = 1'b0;
`ifdef EJTAG_HS_TX_TIMEOUT_EN
    w_cnt_d   = r_cnt;
    w_to_d    = r_to;
    w_err_d   = 1'b0;
`endif
    unique case (r_state)
      StIdle: begin
        if (SEND_VALID && w_ready) begin
          w_state_d = StWaitHi;
          w_data_d  = SEND_DATA;
`ifdef EJTAG_HS_TX_TIMEOUT_EN
          w_cnt_d   = '0;
          w_to_d    = 1'b0;
`endif
        end
      end
      StWaitHi: begin
        if (w_ack_s) begin
          w_state_d = StWaitLo;
`ifdef EJTAG_HS_TX_TIMEOUT_EN
        end else if (r_cnt == CntW'(TO_CYC - 1)) begin
          w_state_d = StWaitLo;
          w_err_d   = 1'b1;
          w_to_d    = 1'b1;
          w_cnt_d   = r_cnt + CntW'(1);
        end else begin
          w_cnt_d   = r_cnt + CntW'(1);
`endif
        end
      end
      StWaitLo: begin
        if (!w_ack_s) begin
          w_state_d = StIdle;
`ifdef EJTAG_HS_TX_TIMEOUT_EN
          w_done_d  = !r_to;
`else
          w_done_d  = 1'b1;
`endif
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= StIdle;
      r_data  <= '0;
      r_req   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_data  <= w_data_d;
      r_req   <= (w_state_d == StWaitHi);
      r_done  <= w_done_d;
    end
  end

`ifdef EJTAG_HS_TX_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt <= '0;
      r_to  <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_d;
      r_to  <= w_to_d;
      r_err <= w_err_d;
    end
  end

  assign ERR = r_err;
`else
  // Always 0; TO_CYC is referenced only so the parameter is not flagged as unused.
  assign ERR = 1'b0 & (TO_CYC == 0);
`endif

  assign SEND_READY = w_ready;
  assign XFER_REQ   = r_req;
  assign XFER_DATA  = r_data;
  assign DONE       = r_done;

endmodule

// File: tb/tb_ejtag_hs_tx.sv
// Directed, table-driven bench for ejtag_hs_tx plus hand-written stale-ACK, reset and
// timeout sequences; the timeout sequence follows EJTAG_HS_TX_TIMEOUT_EN.
module tb_ejtag_hs_tx;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        SEND_VALID;
  logic [31:0] SEND_DATA;
  logic        SEND_READY;
  logic        XFER_REQ;
  logic [31:0] XFER_DATA;
  logic        XFER_ACK;
  logic        DONE;
  logic        ERR;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  ejtag_hs_tx #(
    .DATA_W (32),
    .TO_CYC (8)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .SEND_VALID (SEND_VALID),
    .SEND_DATA  (SEND_DATA),
    .SEND_READY (SEND_READY),
    .XFER_REQ   (XFER_REQ),
    .XFER_DATA  (XFER_DATA),
    .XFER_ACK   (XFER_ACK),
    .DONE       (DONE),
    .ERR        (ERR)
  );

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        ack;
    logic        e_ready;
    logic        e_req;
    logic [31:0] e_data;
    logic        e_done;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic valid, input logic [31:0] data, input logic ack,
                         input logic e_ready, input logic e_req, input logic [31:0] e_data,
                         input logic e_done);
    vec_t v;
    v.valid   = valid;
    v.data    = data;
    v.ack     = ack;
    v.e_ready = e_ready;
    v.e_req   = e_req;
    v.e_data  = e_data;
    v.e_done  = e_done;
    vecs.push_back(v);
  endtask

  // One transfer with a far side that raises ACK one cycle after seeing REQ and drops it one
  // cycle after REQ falls. k0 is the accept cycle; the caller supplies the DONE/IDLE tail.
  task automatic add_xfer(input logic [31:0] word, input logic noise, input logic [31:0] prev,
                          input logic first_done);
    add_vec(1'b1, word, 1'b0, 1'b1, 1'b0, prev, first_done);
    for (int k = 1; k <= 8; k++) begin
      add_vec(noise, 32'hC0DE_0000 | 32'(k), (k >= 2 && k <= 5), 1'b0, (k <= 4), word, 1'b0);
    end
  endtask

  task automatic add_tail(input logic [31:0] word);
    add_vec(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, word, 1'b1);
    add_vec(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, word, 1'b0);
  endtask

  initial begin
    int err_cyc, err_cnt, done_cnt, req_cnt;
    logic req_at_err, ready_after;

    // Basic transfer, then back-pressure with SEND_VALID held and SEND_DATA churning.
    add_xfer(32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
    add_tail(32'hDEAD_BEEF);
    add_xfer(32'h1111_1111, 1'b1, 32'hDEAD_BEEF, 1'b0);
    add_xfer(32'h2222_2222, 1'b1, 32'h1111_1111, 1'b1);
    add_tail(32'h2222_2222);

    RESET      = 1'b1;
    SEND_VALID = 1'b0;
    SEND_DATA  = 32'h0;
    XFER_ACK   = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset ready", 32'(SEND_READY), 32'd1);
    chk("reset req",   32'(XFER_REQ),   32'd0);
    chk("reset data",  XFER_DATA,       32'h0);
    chk("reset done",  32'(DONE),       32'd0);
    chk("reset err",   32'(ERR),        32'd0);
    RESET = 1'b0;

    foreach (vecs[i]) begin
      @(negedge CLK);
      SEND_VALID = vecs[i].valid;
      SEND_DATA  = vecs[i].data;
      XFER_ACK   = vecs[i].ack;
      #1;
      chk($sformatf("vec%0d ready", i), 32'(SEND_READY), 32'(vecs[i].e_ready));
      chk($sformatf("vec%0d req", i),   32'(XFER_REQ),   32'(vecs[i].e_req));
      chk($sformatf("vec%0d data", i),  XFER_DATA,       vecs[i].e_data);
      chk($sformatf("vec%0d done", i),  32'(DONE),       32'(vecs[i].e_done));
      chk($sformatf("vec%0d err", i),   32'(ERR),        32'd0);
    end

    // Stale ACK held through reset and released 10 cycles later.
    @(negedge CLK);
    RESET      = 1'b1;
    SEND_VALID = 1'b0;
    XFER_ACK   = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    for (int r = 1; r <= 11; r++) begin
      @(negedge CLK);
      SEND_VALID = (r >= 2);
      SEND_DATA  = 32'hBAD0_0000 | 32'(r);
      XFER_ACK   = (r < 10);
      #1;
      if (r >= 2) begin
        chk($sformatf("stale r%0d ready", r), 32'(SEND_READY), 32'd0);
        chk($sformatf("stale r%0d req", r),   32'(XFER_REQ),   32'd0);
      end
    end
    @(negedge CLK);
    SEND_VALID = 1'b1;
    SEND_DATA  = 32'h5A5A_5A5A;
    #1;
    chk("stale release ready", 32'(SEND_READY), 32'd1);
    chk("stale release req",   32'(XFER_REQ),   32'd0);
    @(negedge CLK);
    SEND_VALID = 1'b0;
    #1;
    chk("stale accept req",  32'(XFER_REQ), 32'd1);
    chk("stale accept data", XFER_DATA,     32'h5A5A_5A5A);

    // Reset pulsed for one cycle while waiting for ACK.
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("midrst before req", 32'(XFER_REQ), 32'd1);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("midrst req",   32'(XFER_REQ),   32'd0);
    chk("midrst data",  XFER_DATA,       32'h0);
    chk("midrst ready", 32'(SEND_READY), 32'd1);
    chk("midrst done",  32'(DONE),       32'd0);
    chk("midrst err",   32'(ERR),        32'd0);
    done_cnt = 0;
    err_cnt  = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      #1;
      done_cnt += int'(DONE);
      err_cnt  += int'(ERR);
    end
    chk("midrst no done", 32'(done_cnt), 32'd0);
    chk("midrst no err",  32'(err_cnt),  32'd0);

    // ACK withheld entirely; REQ first high one cycle after accept.
    @(negedge CLK);
    SEND_VALID = 1'b1;
    SEND_DATA  = 32'h600D_F00D;
    @(negedge CLK);
    SEND_VALID = 1'b0;
    #1;
    chk("noack req rise", 32'(XFER_REQ), 32'd1);
`ifdef EJTAG_HS_TX_TIMEOUT_EN
    err_cyc     = -1;
    err_cnt     = 0;
    done_cnt    = 0;
    req_at_err  = 1'b1;
    ready_after = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) begin
        @(negedge CLK);
        #1;
      end
      if (ERR) begin
        err_cnt++;
        if (err_cyc < 0) begin
          err_cyc    = c;
          req_at_err = XFER_REQ;
        end
      end
      if (err_cyc >= 0 && c == err_cyc + 1) ready_after = SEND_READY;
      done_cnt += int'(DONE);
    end
    chk("timeout err cycle", 32'(err_cyc), 32'd9);
    chk("timeout err width", 32'(err_cnt), 32'd1);
    chk("timeout req drop",  32'(req_at_err), 32'd0);
    chk("timeout idle",      32'(ready_after), 32'd1);
    chk("timeout no done",   32'(done_cnt), 32'd0);
    chk("timeout data held", XFER_DATA, 32'h600D_F00D);
`else
    req_cnt = 0;
    err_cnt = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge CLK);
      #1;
      req_cnt += int'(XFER_REQ);
      err_cnt += int'(ERR);
    end
    chk("noto req held", 32'(req_cnt), 32'd1000);
    chk("noto err zero", 32'(err_cnt), 32'd0);
    chk("noto data held", XFER_DATA, 32'h600D_F00D);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
